// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Memory accesses
// use a ready handshake with a timeout. A bad opcode or an expired timeout
// parks the FSM in TRAP until trap_clr is asserted.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   opcode               instr[6:0] from the IR, sampled in DECODE
//   mem_ready            completes the current imem or dmem access
//   trap_clr             releases TRAP (ignored in every other state)
//   imem_req, dmem_req   memory requests
//   ir_write, pc_write   one-cycle load pulses for the IR and the PC
//   alu_src..alu_op      datapath control, gated by state
//   state, trap_cause    FSM state and reason for the last trap
//   instr_retired        one-cycle pulse per completed instruction
//   retire_cnt           count of retired instructions, wraps
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int EN_UPPER    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             reg_write,
    output logic             jump_sel,
    output logic             jalr_sel,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic [1:0]       trap_cause,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       ld;
        logic       st;
        logic       branch;
        logic       reg_write;
        logic       jump_sel;
        logic       jalr_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] TO_M1  = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          st_q, st_d;
    ctrl_t           ctl_q, ctl_d, dec;
    logic            dec_ok;
    logic [TW-1:0]   tmr_q, tmr_d, tmr_inc;
    logic [1:0]      tc_q, tc_d;
    logic [CNT_W-1:0] cnt_q;
    logic            tmo, show;

    // Opcode to control vector.
    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        case (opcode)
            7'b0110011: dec = 10'b0000010010;
            7'b0010011: dec = 10'b1000010010;
            7'b0000011: dec = 10'b1110010000;
            7'b0100011: dec = 10'b1001000000;
            7'b1100011: dec = 10'b0000100001;
            7'b1101111: dec = 10'b0000111011;
            7'b1100111: dec = 10'b0000111111;
            7'b0110111, 7'b0010111: begin
                if (EN_UPPER != 0) dec = 10'b1000010000;
                else               dec_ok = 1'b0;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // The trap fires on the cycle the wait count would reach MEM_TIMEOUT,
    // so a ready on that same cycle still completes the access.
    assign tmo     = (MEM_TIMEOUT != 0) && !mem_ready && (tmr_q == TO_M1);
    assign tmr_inc = (tmr_q == TO_MAX) ? tmr_q : tmr_q + 1'b1;
    assign show    = (st_q == S_EXEC) || (st_q == S_MEM) || (st_q == S_WB);

    always_comb begin
        st_d          = st_q;
        ctl_d         = ctl_q;
        tmr_d         = '0;     // restarts on every state change
        tc_d          = tc_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        instr_retired = 1'b0;
        case (st_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    st_d     = S_DECODE;
                end else if (tmo) begin
                    st_d = S_TRAP;
                    tc_d = 2'b10;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    ctl_d = dec;
                    st_d  = S_EXEC;
                end else begin
                    ctl_d = '0;
                    st_d  = S_TRAP;
                    tc_d  = 2'b01;
                end
            end
            S_EXEC: begin
                if (ctl_q.ld || ctl_q.st) begin
                    st_d = S_MEM;
                end else if (ctl_q.branch && !ctl_q.jump_sel) begin
                    // Conditional branches finish here; jumps still write rd.
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                    st_d          = S_FETCH;
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (mem_ready) begin
                    if (ctl_q.ld) begin
                        st_d = S_WB;
                    end else begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        st_d          = S_FETCH;
                    end
                end else if (tmo) begin
                    st_d = S_TRAP;
                    tc_d = 2'b10;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_WB: begin
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                st_d          = S_FETCH;
            end
            S_TRAP: begin
                if (trap_clr) begin
                    st_d = S_FETCH;
                    tc_d = 2'b00;
                end
            end
            default: st_d = S_FETCH;
        endcase
        // Outputs stay quiet for as long as reset is held.
        if (!rst_n) begin
            imem_req      = 1'b0;
            dmem_req      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            instr_retired = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= S_FETCH;
            ctl_q <= '0;
            tmr_q <= '0;
            tc_q  <= 2'b00;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            ctl_q <= ctl_d;
            tmr_q <= tmr_d;
            tc_q  <= tc_d;
            if (instr_retired) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign alu_src    = show && ctl_q.alu_src;
    assign mem_to_reg = show && ctl_q.mem_to_reg;
    assign branch     = show && ctl_q.branch;
    assign jump_sel   = show && ctl_q.jump_sel;
    assign jalr_sel   = show && ctl_q.jalr_sel;
    assign alu_op     = show ? ctl_q.alu_op : 2'b00;
    assign mem_read   = (st_q == S_MEM) && ctl_q.ld;
    assign mem_write  = (st_q == S_MEM) && ctl_q.st;
    assign reg_write  = (st_q == S_WB) && ctl_q.reg_write;
    assign state      = st_q;
    assign trap_cause = tc_q;
    assign retire_cnt = cnt_q;

endmodule
